// File: rtl/master_port_serial_if.sv
// Slave-side bus of the serial master port: command handshake, split control
// and the three one-bit serial lanes.
interface master_port_serial_if;
    logic read_en;
    logic write_en;
    logic master_valid;
    logic master_ready;
    logic tx_address;
    logic tx_data;
    logic slave_ready;
    logic slave_valid;
    logic split_en;
    logic rx_data;

    modport master (
        output read_en, write_en, master_valid, master_ready, tx_address, tx_data,
        input  slave_ready, slave_valid, split_en, rx_data
    );

    modport slave (
        input  read_en, write_en, master_valid, master_ready, tx_address, tx_data,
        output slave_ready, slave_valid, split_en, rx_data
    );
endinterface

// File: rtl/master_port_serial.sv
// Serial bus master: handshakes a command, shifts address and write data out
// LSB first, and assembles serial read data, with slave split and timeout.
module master_port_serial #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic [DATA_W-1:0] rdata_out,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    master_port_serial_if.master bus
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_DONE
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              rw_reg;
    logic [ADDR_W-1:0] addr_sh_reg;
    logic [DATA_W-1:0] wdata_sh_reg;
    logic [DATA_W-1:0] rx_sh_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [TMO_W-1:0]  tmo_reg;
    logic              timeout_reg;

    logic              addr_last;
    logic              data_last;
    logic              tmo_hit;
    logic              rx_start;
    logic [DATA_W-1:0] rx_shift;

    assign addr_last = (cnt_reg == CNT_W'(ADDR_W - 1));
    assign data_last = (cnt_reg == CNT_W'(DATA_W - 1));
    assign tmo_hit   = (tmo_reg == TMO_W'(TIMEOUT - 1));
    // A split slave may wiggle slave_valid; only an unsplit valid starts the read.
    assign rx_start  = (state_reg == S_RWAIT) && bus.slave_valid && !bus.split_en;
    assign rx_shift  = DATA_W'({bus.rx_data, rx_sh_reg} >> 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (req) state_next = S_REQ;
            end
            S_REQ: begin
                if (bus.slave_ready)  state_next = S_ADDR;
                else if (tmo_hit)     state_next = S_IDLE;
            end
            S_ADDR: begin
                if (addr_last) state_next = rw_reg ? S_WDATA : S_RWAIT;
            end
            S_WDATA: begin
                if (data_last) state_next = S_DONE;
            end
            S_RWAIT: begin
                // cnt_reg is zero here, so data_last only holds for one-bit data
                if (rx_start) state_next = data_last ? S_DONE : S_RDATA;
            end
            S_RDATA: begin
                if (data_last) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rw_reg       <= 1'b0;
            addr_sh_reg  <= '0;
            wdata_sh_reg <= '0;
            rx_sh_reg    <= '0;
            rdata_reg    <= '0;
            cnt_reg      <= '0;
            tmo_reg      <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        rw_reg       <= rw;
                        addr_sh_reg  <= addr_in;
                        wdata_sh_reg <= wdata_in;
                        rx_sh_reg    <= '0;
                        cnt_reg      <= '0;
                        tmo_reg      <= '0;
                    end
                end
                S_REQ: begin
                    if (!bus.slave_ready) begin
                        if (tmo_hit) timeout_reg <= 1'b1;
                        else         tmo_reg     <= tmo_reg + TMO_W'(1);
                    end
                end
                S_ADDR: begin
                    addr_sh_reg <= addr_sh_reg >> 1;
                    cnt_reg     <= addr_last ? '0 : cnt_reg + CNT_W'(1);
                end
                S_WDATA: begin
                    wdata_sh_reg <= wdata_sh_reg >> 1;
                    cnt_reg      <= cnt_reg + CNT_W'(1);
                end
                S_RWAIT: begin
                    if (rx_start) begin
                        rx_sh_reg <= rx_shift;
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                        if (data_last) rdata_reg <= rx_shift;
                    end
                end
                S_RDATA: begin
                    // The slave streams without gaps once it has started.
                    rx_sh_reg <= rx_shift;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (data_last) rdata_reg <= rx_shift;
                end
                default: begin
                end
            endcase
        end
    end

    assign rdata_out   = rdata_reg;
    assign timeout_err = timeout_reg;

    always_comb begin
        busy             = (state_reg != S_IDLE);
        done             = (state_reg == S_DONE);
        bus.read_en      = 1'b0;
        bus.write_en     = 1'b0;
        bus.master_valid = 1'b0;
        bus.master_ready = 1'b0;
        bus.tx_address   = 1'b0;
        bus.tx_data      = 1'b0;
        case (state_reg)
            S_REQ: begin
                bus.master_valid = 1'b1;
                bus.write_en     = rw_reg;
                bus.read_en      = !rw_reg;
            end
            S_ADDR: begin
                bus.master_valid = 1'b1;
                bus.write_en     = rw_reg;
                bus.read_en      = !rw_reg;
                bus.tx_address   = addr_sh_reg[0];
            end
            S_WDATA: begin
                bus.master_valid = 1'b1;
                bus.write_en     = 1'b1;
                bus.tx_data      = wdata_sh_reg[0];
            end
            S_RWAIT: begin
                bus.read_en      = 1'b1;
                bus.master_ready = !bus.split_en;
            end
            S_RDATA: begin
                bus.read_en      = 1'b1;
                bus.master_ready = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_master_port_serial.sv
// Directed bench for master_port_serial: write, read, split, timeout, reset
// and held-request scenarios at the default parameters.
module tb_master_port_serial;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int TO     = 255;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req = 1'b0;
    logic              rw = 1'b0;
    logic [ADDR_W-1:0] addr_in = '0;
    logic [DATA_W-1:0] wdata_in = '0;
    logic [DATA_W-1:0] rdata_out;
    logic              busy;
    logic              done;
    logic              timeout_err;

    master_port_serial_if bus ();

    master_port_serial #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .rw         (rw),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .rdata_out  (rdata_out),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Bit sequences worked out by hand from 0xA5C and 0x3B, LSB first.
    bit abits[12] = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
    bit dbits[8]  = '{1, 1, 0, 1, 1, 1, 0, 0};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] all_outs();
        return {rdata_out, busy, done, timeout_err, bus.read_en, bus.write_en,
                bus.master_valid, bus.master_ready, bus.tx_address, bus.tx_data};
    endfunction

    // Starts a read and stops on the first RWAIT cycle (14 edges after req).
    task automatic go_to_rwait(input logic [ADDR_W-1:0] a, input string tg);
        logic [ADDR_W-1:0] seen;
        seen = '0;
        rw = 1'b0;
        addr_in = a;
        bus.slave_ready = 1'b1;
        req = 1'b1;
        tick;
        req = 1'b0;
        check({tg, "_req_rd_en"}, {bus.read_en, bus.write_en, bus.master_valid}, 3'b101);
        for (int n = 0; n < ADDR_W; n++) begin
            tick;
            seen[n] = bus.tx_address;
        end
        check({tg, "_addr_bits"}, seen, a);
        tick;
        check({tg, "_rwait_outs"}, {bus.read_en, bus.master_valid, busy}, 3'b101);
    endtask

    // Slave streams a byte: valid only with bit 0, then bits 1..7 back to back.
    task automatic rx_byte(input logic [DATA_W-1:0] b, input string tg);
        int early_done;
        int mr_low;
        early_done = 0;
        mr_low = 0;
        for (int i = 0; i < DATA_W; i++) begin
            bus.rx_data = b[i];
            bus.slave_valid = (i == 0);
            tick;
            if (i < DATA_W - 1) begin
                early_done += int'(done);
                mr_low += int'(!bus.master_ready);
            end
        end
        bus.slave_valid = 1'b0;
        bus.rx_data = 1'b0;
        check({tg, "_early_done"}, early_done, 0);
        check({tg, "_rdata_mready_low"}, mr_low, 0);
        check({tg, "_done"}, {done, busy, bus.read_en}, 3'b110);
        check({tg, "_rdata"}, rdata_out, b);
        tick;
        check({tg, "_idle"}, {done, busy}, 2'b00);
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        int cnt_c;

        bus.slave_ready = 1'b0;
        bus.slave_valid = 1'b0;
        bus.split_en    = 1'b0;
        bus.rx_data     = 1'b0;

        // ---- reset state, req ignored while reset is low
        tick;
        tick;
        check("reset_outs", all_outs(), 17'h0);
        req = 1'b1;
        rw = 1'b1;
        tick;
        check("reset_req_ignored", busy, 1'b0);
        req = 1'b0;
        reset = 1'b1;
        tick;
        check("post_reset_idle", all_outs(), 17'h0);
        $display("[TB] reset: outputs 0x%0h", all_outs());

        // ---- write 0x3B to 0xA5C, slave ready at once
        rw = 1'b1;
        addr_in = 12'hA5C;
        wdata_in = 8'h3B;
        bus.slave_ready = 1'b1;
        req = 1'b1;
        cnt_a = 0;
        for (int n = 1; n <= 22; n++) begin
            tick;
            if (n == 1) begin
                req = 1'b0;
                check("wr_req_outs", {bus.master_valid, bus.write_en, bus.read_en, busy}, 4'b1101);
            end
            if (n >= 2 && n <= 13) begin
                check($sformatf("wr_addr_bit%0d", n - 2), bus.tx_address, abits[n-2]);
                check($sformatf("wr_addr_txd%0d", n - 2), bus.tx_data, 1'b0);
            end
            if (n >= 14 && n <= 21) begin
                check($sformatf("wr_data_bit%0d", n - 14), bus.tx_data, dbits[n-14]);
                check($sformatf("wr_data_txa%0d", n - 14), {bus.tx_address, bus.master_valid, bus.write_en}, 3'b011);
            end
            if (n < 22) cnt_a += int'(done);
        end
        check("wr_done_at_22", done, 1'b1);
        check("wr_no_early_done", cnt_a, 0);
        check("wr_done_bus_idle", {bus.master_valid, bus.write_en, bus.tx_data}, 3'b000);
        check("wr_rdata_unchanged", rdata_out, 8'h00);
        tick;
        check("wr_back_idle", {busy, done}, 2'b00);
        $display("[TB] write addr=0xA5C data=0x3B done after 22 edges");

        // ---- read from 0x001, slave_valid after 5 RWAIT cycles, byte 0xC4
        go_to_rwait(12'h001, "rd");
        for (int w = 0; w < 4; w++) begin
            tick;
            check($sformatf("rd_wait%0d", w), {bus.master_ready, done, busy}, 3'b101);
        end
        rx_byte(8'hC4, "rd");
        $display("[TB] read addr=0x001 rdata=0x%0h", rdata_out);

        // ---- split: 40 cycles with slave_valid pulses that must be ignored
        go_to_rwait(12'h7F0, "sp");
        bus.split_en = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        for (int c = 0; c < 40; c++) begin
            bus.slave_valid = (c == 10 || c == 25);
            bus.rx_data = 1'b1;
            #1;
            cnt_a += int'(bus.master_ready);
            tick;
            cnt_b += int'(done) + int'(timeout_err);
            cnt_c += int'(!bus.read_en);
        end
        bus.slave_valid = 1'b0;
        bus.rx_data = 1'b0;
        check("sp_mready_low", cnt_a, 0);
        check("sp_no_done_or_timeout", cnt_b, 0);
        check("sp_still_reading", cnt_c, 0);
        check("sp_rdata_held", rdata_out, 8'hC4);
        bus.split_en = 1'b0;
        #1;
        check("sp_mready_release", bus.master_ready, 1'b1);
        tick;
        rx_byte(8'h5A, "sp");
        $display("[TB] split read rdata=0x%0h", rdata_out);

        // ---- timeout: slave never ready
        rw = 1'b1;
        addr_in = 12'h055;
        bus.slave_ready = 1'b0;
        req = 1'b1;
        tick;
        req = 1'b0;
        cnt_a = 0;
        for (int n = 2; n <= TO; n++) begin
            tick;
            cnt_a += int'(timeout_err) + int'(!busy) + int'(done);
        end
        check("to_waiting", cnt_a, 0);
        check("to_last_req", {busy, bus.master_valid, bus.write_en}, 3'b111);
        tick;
        check("to_pulse", {timeout_err, busy, done, bus.master_valid, bus.write_en}, 5'b10000);
        tick;
        check("to_pulse_end", {timeout_err, busy, done}, 3'b000);
        check("to_rdata_held", rdata_out, 8'h5A);
        $display("[TB] timeout after %0d REQ cycles", TO);

        // ---- reset during the 4th ADDR cycle, then a clean read
        rw = 1'b1;
        addr_in = 12'hA5C;
        wdata_in = 8'h3B;
        bus.slave_ready = 1'b1;
        req = 1'b1;
        tick;
        req = 1'b0;
        for (int n = 0; n < 4; n++) tick;
        check("rst_addr_bit3", {bus.tx_address, busy}, {abits[3], 1'b1});
        reset = 1'b0;
        tick;
        check("rst_mid_outs", all_outs(), 17'h0);
        reset = 1'b1;
        tick;
        check("rst_released_idle", busy, 1'b0);
        go_to_rwait(12'h3C3, "rr");
        rx_byte(8'h96, "rr");
        $display("[TB] reset mid-transaction then read rdata=0x%0h", rdata_out);

        // ---- req held high across a write
        rw = 1'b1;
        addr_in = 12'h123;
        wdata_in = 8'h55;
        bus.slave_ready = 1'b1;
        req = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int n = 1; n <= 22; n++) begin
            tick;
            if (n < 22) cnt_a += int'(done);
            cnt_b += int'(!busy);
        end
        check("hold_no_early_done", cnt_a, 0);
        check("hold_busy_through", cnt_b, 0);
        check("hold_done", done, 1'b1);
        tick;
        check("hold_idle_gap", {busy, done}, 2'b00);
        check("hold_rdata_unchanged", rdata_out, 8'h96);
        tick;
        check("hold_reaccept", busy, 1'b1);
        req = 1'b0;
        for (int n = 0; n < 21; n++) tick;
        check("hold_second_done", done, 1'b1);
        check("hold_rdata_still", rdata_out, 8'h96);
        tick;
        check("hold_final_idle", busy, 1'b0);
        $display("[TB] held req: one transaction per IDLE visit");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/master_port_serial.md
MASTER_PORT_SERIAL -- requirements
Module: master_port_serial

Interface
REQ-001 The block SHALL have a parameter ADDR_W, default 12, giving the serial address length in bits.
REQ-002 The block SHALL have a parameter DATA_W, default 8, giving the serial data length in bits.
REQ-003 The block SHALL have a parameter TIMEOUT, default 255, giving the maximum number of cycles spent waiting for slave_ready.
REQ-004 The block SHALL have a port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have a port reset, input, 1 bit: synchronous, active-low reset (reset==0 at a clk edge resets).
REQ-006 The block SHALL have a port req, input, 1 bit: user transaction request, sampled only in IDLE.
REQ-007 The block SHALL have a port rw, input, 1 bit: 1=write, 0=read, latched with req.
REQ-008 The block SHALL have a port addr_in, input, ADDR_W bits: target address, latched with req.
REQ-009 The block SHALL have a port wdata_in, input, DATA_W bits: write data, latched with req.
REQ-010 The block SHALL have a port rdata_out, output, DATA_W bits: last completed read data.
REQ-011 The block SHALL have a port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have a port done, output, 1 bit: one-cycle pulse on transaction completion.
REQ-013 The block SHALL have a port timeout_err, output, 1 bit: one-cycle pulse when the slave_ready wait expires.
REQ-014 The block SHALL have a port read_en, output, 1 bit: read command to slave.
REQ-015 The block SHALL have a port write_en, output, 1 bit: write command to slave.
REQ-016 The block SHALL have a port master_valid, output, 1 bit: master driving valid command/address/write bits.
REQ-017 The block SHALL have a port master_ready, output, 1 bit: master ready to accept read data.
REQ-018 The block SHALL have a port slave_ready, input, 1 bit: slave accepts the command.
REQ-019 The block SHALL have a port slave_valid, input, 1 bit: slave starts driving read data.
REQ-020 The block SHALL have a port split_en, input, 1 bit: slave has split the transaction (read data deferred).
REQ-021 The block SHALL have a port tx_address, output, 1 bit: serial address, LSB first.
REQ-022 The block SHALL have a port tx_data, output, 1 bit: serial write data, LSB first.
REQ-023 The block SHALL have a port rx_data, input, 1 bit: serial read data, LSB first.

Function
REQ-024 The FSM SHALL have states IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, DONE, with all state and output registers updated on the clk rising edge.
REQ-025 In IDLE with req=1, the block SHALL latch rw, addr_in and wdata_in, clear the bit and timeout counters, and go to REQ next cycle; req in any other state SHALL be ignored.
REQ-026 In REQ, the block SHALL assert master_valid=1 and write_en=rw or read_en=~rw; on slave_ready=1 it SHALL go to ADDR, otherwise increment the timeout counter.
REQ-027 When the timeout counter reaches TIMEOUT in REQ, the block SHALL pulse timeout_err for one cycle, deassert all bus outputs, and go to IDLE without pulsing done.
REQ-028 In ADDR, the block SHALL hold read_en/write_en and master_valid and drive tx_address with address bit k on the k-th ADDR cycle (k=0..ADDR_W-1), taking exactly ADDR_W cycles.
REQ-029 After ADDR, the block SHALL go to WDATA if rw=1 or to RWAIT if rw=0.
REQ-030 In WDATA, the block SHALL drive tx_data with data bit k for DATA_W cycles with master_valid=1 and write_en=1, then go to DONE.
REQ-031 In RWAIT, the block SHALL hold read_en=1, master_valid=0, and master_ready=~split_en.
REQ-032 While split_en=1 in RWAIT, the block SHALL wait indefinitely with no timeout and SHALL ignore slave_valid.
REQ-033 In RWAIT, slave_valid=1 with split_en=0 SHALL sample rx_data as bit 0 in the same cycle and go to RDATA.
REQ-034 RDATA SHALL sample bits 1..DATA_W-1 on the next DATA_W-1 consecutive cycles regardless of slave_valid, with master_ready=1, then go to DONE.
REQ-035 In DONE, the block SHALL assert done=1 for exactly one cycle, update rdata_out with the assembled byte for a read (unchanged for a write), deassert all bus outputs, and return to IDLE.
REQ-036 rdata_out SHALL change only in DONE of a read, or on reset.
REQ-037 The next req SHALL be accepted no earlier than the cycle after DONE.
REQ-038 Write latency from req to done SHALL be 1 + (REQ wait cycles) + ADDR_W + DATA_W + 1 cycles, i.e. 22 at the defaults with immediate slave_ready.
REQ-039 tx_address and tx_data SHALL be 0 outside ADDR and WDATA respectively.

Reset
REQ-040 On reset==0, the block SHALL go to IDLE and clear all counters and shift registers at the next clk edge, including mid-transaction.
REQ-041 On reset==0, all outputs (rdata_out, busy, done, timeout_err, read_en, write_en, master_valid, master_ready, tx_address, tx_data) SHALL be 0.
REQ-042 The block SHALL not act on req in the cycle in which reset==0.

Verification
REQ-043 Write scenario: rw=1, addr_in=0xA5C, wdata_in=0x3B, with slave_ready high -> tx_address bits 0,0,1,1,1,0,1,0,0,1,0,1 then tx_data bits 1,1,0,1,1,1,0,0; done at cycle 22.
REQ-044 Read scenario: rw=0, addr 0x001, slave_valid after 5 cycles, rx_data sending 0xC4 LSB first -> rdata_out=0xC4 and done=1 one cycle after the last bit.
REQ-045 Split scenario: split_en=1 for 40 cycles during RWAIT with slave_valid pulsed inside the window -> master_ready=0, no sampling; after split_en=0 and slave_valid -> correct byte, no timeout_err.
REQ-046 Timeout scenario: slave_ready held 0 -> timeout_err pulses at TIMEOUT cycles, then IDLE, done never asserted, busy=0.
REQ-047 Reset scenario: reset=0 at the 4th ADDR cycle -> all outputs 0 next cycle; a new req after release completes normally.
REQ-048 Ignored-request scenario: req held high throughout a transaction -> exactly one transaction per IDLE visit and rdata_out unchanged after a write.
